// File: rtl/exec_pkg.sv
// Shared types and instruction field positions for the exec unit.
package exec_pkg;

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_AND   = 4'd2,
    OP_OR    = 4'd3,
    OP_LI    = 4'd4,
    OP_LOAD  = 4'd5,
    OP_STORE = 4'd6,
    OP_JR    = 4'd7,
    OP_HALT  = 4'd15
  } op_e;

  typedef enum logic [2:0] {
    ST_BOOT,
    ST_EXEC,
    ST_MEM_WAIT,
    ST_REDIRECT,
    ST_HALT
  } state_e;

  // Field positions of the register-format instruction (bit 12 set).
  localparam int unsigned FMT_BIT = 12;
  localparam int unsigned OP_HI   = 11;
  localparam int unsigned OP_LO   = 8;
  localparam int unsigned RD_HI   = 7;
  localparam int unsigned RD_LO   = 6;
  localparam int unsigned RS_HI   = 5;
  localparam int unsigned RS_LO   = 4;
  localparam int unsigned IMM_HI  = 5;
  localparam int unsigned IMM_LO  = 0;

endpackage

// File: rtl/exec_regfile.sv
// Four-entry register file: two asynchronous read ports, one write port.
module exec_regfile #(
  parameter int unsigned I_WIDTH = 13
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         raddr_a,
  output logic [I_WIDTH-1:0] rdata_a,
  input  logic [1:0]         raddr_b,
  output logic [I_WIDTH-1:0] rdata_b,
  input  logic               we,
  input  logic [1:0]         waddr,
  input  logic [I_WIDTH-1:0] wdata
);

  logic [I_WIDTH-1:0] regs [4];

  // Register storage: cleared on reset, single write per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 4; i++) regs[i] <= '0;
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a = regs[raddr_a];
  assign rdata_b = regs[raddr_b];

endmodule

// File: rtl/exec_unit.sv
// In-order execute stage: consumes the fetch queue head, runs ALU ops,
// issues single-outstanding loads/stores and redirects fetch when needed.
module exec_unit
  import exec_pkg::*;
#(
  parameter int unsigned I_WIDTH = 13,
  parameter int unsigned A_WIDTH = 10,
  parameter int unsigned O_WIDTH = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [I_WIDTH-1:0] instruction_data_i,
  input  logic [A_WIDTH-1:0] instruction_addr_i,
  input  logic               instruction_valid_i,
  output logic               dequeue_o,
  output logic               restart_o,
  output logic [A_WIDTH-1:0] restart_addr_o,
  output logic               load_store_valid_o,
  output logic               store_en_o,
  output logic [A_WIDTH-1:0] load_store_addr_o,
  output logic [I_WIDTH-1:0] store_data_o,
  input  logic [I_WIDTH-1:0] load_data_i,
  input  logic               load_data_valid_i,
  output logic               halted_o,
  output logic [15:0]        retired_count_o
);

  state_e             state_q, state_d;
  logic [A_WIDTH-1:0] pc_q;
  logic [1:0]         rd_q;
  logic               halted_q;
  logic [15:0]        count_q;

  logic               is_bz;
  op_e                op;
  logic [1:0]         rd_idx, rs_idx, rb_idx;
  logic [I_WIDTH-1:0] ra_val, rb_val, alu_res;

  logic               we;
  logic [1:0]         waddr;
  logic [I_WIDTH-1:0] wdata;
  logic               retire, latch, set_halt;

  assign is_bz  = ~instruction_data_i[FMT_BIT];
  assign op     = op_e'(instruction_data_i[OP_HI:OP_LO]);
  assign rd_idx = instruction_data_i[RD_HI:RD_LO];
  assign rs_idx = instruction_data_i[RS_HI:RS_LO];
  // The BZ source register sits directly above the branch offset.
  assign rb_idx = is_bz ? instruction_data_i[O_WIDTH +: 2] : rs_idx;

  exec_regfile #(.I_WIDTH(I_WIDTH)) u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .raddr_a (rd_idx),
    .rdata_a (ra_val),
    .raddr_b (rb_idx),
    .rdata_b (rb_val),
    .we      (we),
    .waddr   (waddr),
    .wdata   (wdata)
  );

  // ALU: two-operand ops rd <= rd op rs, LI loads the zero-extended immediate.
  always_comb begin
    case (op)
      OP_ADD:  alu_res = ra_val + rb_val;
      OP_SUB:  alu_res = ra_val - rb_val;
      OP_AND:  alu_res = ra_val & rb_val;
      OP_OR:   alu_res = ra_val | rb_val;
      OP_LI:   alu_res = I_WIDTH'(instruction_data_i[IMM_HI:IMM_LO]);
      default: alu_res = '0;
    endcase
  end

  // Control decode: combinational strobes, next state and bookkeeping enables.
  always_comb begin
    dequeue_o          = 1'b0;
    restart_o          = 1'b0;
    restart_addr_o     = '0;
    load_store_valid_o = 1'b0;
    store_en_o         = 1'b0;
    load_store_addr_o  = '0;
    store_data_o       = '0;
    we                 = 1'b0;
    waddr              = rd_idx;
    wdata              = alu_res;
    state_d            = state_q;
    retire             = 1'b0;
    latch              = 1'b0;
    set_halt           = 1'b0;
    // Strobes are held low for the whole reset, including the BOOT restart.
    if (rst_n) begin
      case (state_q)
        ST_BOOT: begin
          restart_o = 1'b1;
          state_d   = ST_EXEC;
        end
        ST_EXEC: begin
          if (instruction_valid_i) begin
            if (is_bz) begin
              retire = 1'b1;
              if (rb_val == '0) begin
                dequeue_o = 1'b1;
              end else begin
                restart_o      = 1'b1;
                restart_addr_o = instruction_addr_i + A_WIDTH'(1);
              end
            end else begin
              case (op)
                OP_ADD, OP_SUB, OP_AND, OP_OR, OP_LI: begin
                  we        = 1'b1;
                  dequeue_o = 1'b1;
                  retire    = 1'b1;
                end
                OP_LOAD: begin
                  load_store_valid_o = 1'b1;
                  load_store_addr_o  = rb_val[A_WIDTH-1:0];
                  latch              = 1'b1;
                  state_d            = ST_MEM_WAIT;
                end
                OP_STORE: begin
                  load_store_valid_o = 1'b1;
                  store_en_o         = 1'b1;
                  load_store_addr_o  = ra_val[A_WIDTH-1:0];
                  store_data_o       = rb_val;
                  latch              = 1'b1;
                  retire             = 1'b1;
                  state_d            = ST_REDIRECT;
                end
                OP_JR: begin
                  restart_o      = 1'b1;
                  restart_addr_o = rb_val[A_WIDTH-1:0];
                  retire         = 1'b1;
                end
                OP_HALT: begin
                  dequeue_o = 1'b1;
                  retire    = 1'b1;
                  set_halt  = 1'b1;
                  state_d   = ST_HALT;
                end
                default: begin
                  dequeue_o = 1'b1;
                  retire    = 1'b1;
                end
              endcase
            end
          end
        end
        ST_MEM_WAIT: begin
          if (load_data_valid_i) begin
            we      = 1'b1;
            waddr   = rd_q;
            wdata   = load_data_i;
            retire  = 1'b1;
            state_d = ST_REDIRECT;
          end
        end
        ST_REDIRECT: begin
          restart_o      = 1'b1;
          restart_addr_o = pc_q + A_WIDTH'(1);
          state_d        = ST_EXEC;
        end
        ST_HALT: ;
        default: state_d = ST_BOOT;
      endcase
    end
  end

  // State, issue-time PC/rd capture, halt flag and retire counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_BOOT;
      pc_q     <= '0;
      rd_q     <= '0;
      halted_q <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q <= state_d;
      if (latch) begin
        pc_q <= instruction_addr_i;
        rd_q <= rd_idx;
      end
      if (set_halt) halted_q <= 1'b1;
      if (retire) count_q <= count_q + 16'd1;
    end
  end

  assign halted_o        = halted_q;
  assign retired_count_o = count_q;

endmodule

// File: tb/tb_exec_unit.sv
// Self-checking bench for exec_unit: directed scenarios plus randomized
// instruction streams checked against a transaction-level model.
module tb_exec_unit;

  logic        clk;
  logic        rst_n;
  logic [12:0] instruction_data_i;
  logic [9:0]  instruction_addr_i;
  logic        instruction_valid_i;
  logic        dequeue_o;
  logic        restart_o;
  logic [9:0]  restart_addr_o;
  logic        load_store_valid_o;
  logic        store_en_o;
  logic [9:0]  load_store_addr_o;
  logic [12:0] store_data_o;
  logic [12:0] load_data_i;
  logic        load_data_valid_i;
  logic        halted_o;
  logic [15:0] retired_count_o;

  int unsigned n_total;
  int unsigned n_pass;
  int unsigned n_fail;

  logic [12:0] m_reg [4];
  int unsigned m_count;
  logic        m_halted;

  exec_unit #(.I_WIDTH(13), .A_WIDTH(10), .O_WIDTH(5)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .instruction_data_i  (instruction_data_i),
    .instruction_addr_i  (instruction_addr_i),
    .instruction_valid_i (instruction_valid_i),
    .dequeue_o           (dequeue_o),
    .restart_o           (restart_o),
    .restart_addr_o      (restart_addr_o),
    .load_store_valid_o  (load_store_valid_o),
    .store_en_o          (store_en_o),
    .load_store_addr_o   (load_store_addr_o),
    .store_data_o        (store_data_o),
    .load_data_i         (load_data_i),
    .load_data_valid_i   (load_data_valid_i),
    .halted_o            (halted_o),
    .retired_count_o     (retired_count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_outs(input string tag, input logic deq, input logic rst,
                             input logic [9:0] raddr, input logic lsv, input logic sten,
                             input logic [9:0] lsaddr, input logic [12:0] sdata);
    check({tag, ".dequeue"},      32'(dequeue_o),          32'(deq));
    check({tag, ".restart"},      32'(restart_o),          32'(rst));
    check({tag, ".restart_addr"}, 32'(restart_addr_o),     32'(raddr));
    check({tag, ".ls_valid"},     32'(load_store_valid_o), 32'(lsv));
    check({tag, ".store_en"},     32'(store_en_o),         32'(sten));
    check({tag, ".ls_addr"},      32'(load_store_addr_o),  32'(lsaddr));
    check({tag, ".store_data"},   32'(store_data_o),       32'(sdata));
  endtask

  task automatic check_status(input string tag);
    check({tag, ".retired"}, 32'(retired_count_o), m_count & 32'hFFFF);
    check({tag, ".halted"},  32'(halted_o),        32'(m_halted));
  endtask

  function automatic logic [12:0] enc(input int unsigned op, input int unsigned rd, input int unsigned rs);
    return 13'h1000 | 13'((op & 15) << 8) | 13'((rd & 3) << 6) | 13'((rs & 3) << 4);
  endfunction

  function automatic logic [12:0] enc_li(input int unsigned rd, input int unsigned imm);
    return 13'h1000 | 13'(4 << 8) | 13'((rd & 3) << 6) | 13'(imm & 63);
  endfunction

  function automatic logic [12:0] enc_bz(input int unsigned rs, input int unsigned off);
    return 13'((rs & 3) << 5) | 13'(off & 31);
  endfunction

  // Idle cycle: nothing may assert, optionally with a stray load-return strobe.
  task automatic idle(input string tag, input logic stray);
    instruction_valid_i = 1'b0;
    load_data_valid_i   = stray;
    load_data_i         = 13'($urandom);
    @(negedge clk);
    expect_outs(tag, 1'b0, 1'b0, 10'd0, 1'b0, 1'b0, 10'd0, 13'd0);
    @(posedge clk); #1;
    load_data_valid_i = 1'b0;
    check_status(tag);
  endtask

  // Called with rst_n already low: checks the reset view, releases, checks BOOT.
  task automatic reset_seq(input string tag);
    instruction_valid_i = 1'b0;
    @(negedge clk);
    expect_outs({tag, ".in_reset"}, 1'b0, 1'b0, 10'd0, 1'b0, 1'b0, 10'd0, 13'd0);
    check({tag, ".in_reset.retired"}, 32'(retired_count_o), 32'd0);
    check({tag, ".in_reset.halted"},  32'(halted_o),        32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    load_data_valid_i = 1'b0;
    for (int k = 0; k < 4; k++) m_reg[k] = '0;
    m_count  = 0;
    m_halted = 1'b0;
    @(negedge clk);
    expect_outs({tag, ".boot"}, 1'b0, 1'b1, 10'd0, 1'b0, 1'b0, 10'd0, 13'd0);
    @(posedge clk); #1;
    idle({tag, ".post_boot"}, 1'b0);
  endtask

  // Run one instruction to completion against the model; entered and left at posedge+1.
  task automatic run_instr(input string tag, input logic [12:0] ins, input logic [9:0] pc,
                           input int unsigned lat, input logic [12:0] ldata);
    int unsigned op, rd, rs, bzs;
    logic [12:0] a, b, res;
    logic [9:0]  nxt;
    op  = int'(ins[11:8]);
    rd  = int'(ins[7:6]);
    rs  = int'(ins[5:4]);
    bzs = int'(ins[6:5]);
    a   = m_reg[rd];
    b   = m_reg[rs];
    nxt = pc + 10'd1;
    instruction_data_i  = ins;
    instruction_addr_i  = pc;
    instruction_valid_i = 1'b1;
    load_data_valid_i   = 1'b0;
    @(negedge clk);
    if (!ins[12]) begin
      if (m_reg[bzs] == 13'd0)
        expect_outs({tag, ".bz_taken"}, 1'b1, 1'b0, 10'd0, 1'b0, 1'b0, 10'd0, 13'd0);
      else
        expect_outs({tag, ".bz_restart"}, 1'b0, 1'b1, nxt, 1'b0, 1'b0, 10'd0, 13'd0);
      @(posedge clk); #1;
      m_count++;
    end else if (op <= 4) begin
      case (op)
        0:       res = 13'((int'(a) + int'(b)) % 8192);
        1:       res = 13'((int'(a) + 8192 - int'(b)) % 8192);
        2:       res = a & b;
        3:       res = a | b;
        default: res = ins & 13'h003F;
      endcase
      expect_outs({tag, ".alu"}, 1'b1, 1'b0, 10'd0, 1'b0, 1'b0, 10'd0, 13'd0);
      @(posedge clk); #1;
      m_reg[rd] = res;
      m_count++;
    end else if (op == 5) begin
      expect_outs({tag, ".load_req"}, 1'b0, 1'b0, 10'd0, 1'b1, 1'b0, b[9:0], 13'd0);
      @(posedge clk); #1;
      for (int unsigned k = 1; k < lat; k++) begin
        load_data_i = 13'($urandom);
        @(negedge clk);
        expect_outs({tag, ".load_wait"}, 1'b0, 1'b0, 10'd0, 1'b0, 1'b0, 10'd0, 13'd0);
        @(posedge clk); #1;
      end
      load_data_valid_i = 1'b1;
      load_data_i       = ldata;
      @(negedge clk);
      expect_outs({tag, ".load_data"}, 1'b0, 1'b0, 10'd0, 1'b0, 1'b0, 10'd0, 13'd0);
      @(posedge clk); #1;
      load_data_valid_i = 1'b0;
      m_reg[rd] = ldata;
      m_count++;
      @(negedge clk);
      expect_outs({tag, ".load_redirect"}, 1'b0, 1'b1, nxt, 1'b0, 1'b0, 10'd0, 13'd0);
      @(posedge clk); #1;
    end else if (op == 6) begin
      expect_outs({tag, ".store_req"}, 1'b0, 1'b0, 10'd0, 1'b1, 1'b1, a[9:0], b);
      @(posedge clk); #1;
      m_count++;
      @(negedge clk);
      expect_outs({tag, ".store_redirect"}, 1'b0, 1'b1, nxt, 1'b0, 1'b0, 10'd0, 13'd0);
      @(posedge clk); #1;
    end else if (op == 7) begin
      expect_outs({tag, ".jr"}, 1'b0, 1'b1, b[9:0], 1'b0, 1'b0, 10'd0, 13'd0);
      @(posedge clk); #1;
      m_count++;
    end else begin
      expect_outs({tag, ".deq"}, 1'b1, 1'b0, 10'd0, 1'b0, 1'b0, 10'd0, 13'd0);
      @(posedge clk); #1;
      m_count++;
      if (op == 15) m_halted = 1'b1;
    end
    instruction_valid_i = 1'b0;
    check_status(tag);
  endtask

  // Expose every register through STORE [r0], rk.
  task automatic dump_regs(input string tag);
    for (int unsigned k = 0; k < 4; k++)
      run_instr(tag, enc(6, 0, k), 10'(100 + k), 1, 13'd0);
  endtask

  initial begin
    logic [12:0] ins;
    n_total = 0; n_pass = 0; n_fail = 0;
    rst_n = 1'b0;
    instruction_data_i = '0; instruction_addr_i = '0; instruction_valid_i = 1'b0;
    load_data_i = '0; load_data_valid_i = 1'b0;
    m_count = 0; m_halted = 1'b0;
    for (int k = 0; k < 4; k++) m_reg[k] = '0;
    repeat (2) @(posedge clk);
    #1;
    reset_seq("reset");

    run_instr("li_r1_5", enc_li(1, 5), 10'd0, 1, 13'd0);
    run_instr("add_r1_r1", enc(0, 1, 1), 10'd1, 1, 13'd0);
    check("add.retired_is_2", 32'(retired_count_o), 32'd2);
    run_instr("show_r1", enc(6, 0, 1), 10'd2, 1, 13'd0);

    run_instr("li_r2_3", enc_li(2, 3), 10'd5, 1, 13'd0);
    run_instr("bz_r2_pc7", enc_bz(2, 5'h1F), 10'd7, 1, 13'd0);
    run_instr("bz_r0", enc_bz(0, 3), 10'd9, 1, 13'd0);
    run_instr("bz_r2_pcwrap", enc_bz(2, 1), 10'h3FF, 1, 13'd0);
    idle("stray_load_valid", 1'b1);

    run_instr("load_r1_r0", enc(5, 1, 0), 10'd4, 3, 13'h1ABC);
    run_instr("show_load", enc(6, 0, 1), 10'd6, 1, 13'd0);
    run_instr("sub_wrap", enc(1, 3, 1), 10'd8, 1, 13'd0);
    run_instr("jr_r1", enc(7, 0, 1), 10'd10, 1, 13'd0);
    run_instr("nop", enc(9, 2, 2), 10'd11, 1, 13'd0);
    dump_regs("dump_directed");

    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        idle("rand_idle", 1'($urandom));
      end else begin
        ins = 13'($urandom);
        if ($urandom_range(0, 4) == 0) ins[12] = 1'b0;
        else begin
          ins[12] = 1'b1;
          ins[11:8] = 4'($urandom_range(0, 14));
        end
        run_instr("rand", ins, 10'($urandom), $urandom_range(1, 4), 13'($urandom));
      end
    end
    dump_regs("dump_random");

    // Reset while a load is outstanding: the returning data must not land.
    run_instr("li_r2_9", enc_li(2, 9), 10'd20, 1, 13'd0);
    instruction_data_i  = enc(5, 2, 0);
    instruction_addr_i  = 10'd21;
    instruction_valid_i = 1'b1;
    @(negedge clk);
    expect_outs("midload.req", 1'b0, 1'b0, 10'd0, 1'b1, 1'b0, 10'd0, 13'd0);
    @(posedge clk); #1;
    @(negedge clk);
    expect_outs("midload.wait", 1'b0, 1'b0, 10'd0, 1'b0, 1'b0, 10'd0, 13'd0);
    #1;
    rst_n = 1'b0;
    load_data_valid_i = 1'b1;
    load_data_i = 13'h0FFF;
    reset_seq("midload_reset");
    dump_regs("dump_after_reset");

    run_instr("li_r3_7", enc_li(3, 7), 10'd30, 1, 13'd0);
    run_instr("store_final", enc(6, 3, 3), 10'd31, 1, 13'd0);
    run_instr("halt", enc(15, 0, 0), 10'd32, 1, 13'd0);
    for (int i = 0; i < 4; i++) begin
      instruction_data_i  = enc_li(1, 1);
      instruction_addr_i  = 10'(33 + i);
      instruction_valid_i = 1'b1;
      @(negedge clk);
      expect_outs("after_halt", 1'b0, 1'b0, 10'd0, 1'b0, 1'b0, 10'd0, 13'd0);
      @(posedge clk); #1;
      check_status("after_halt");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
